// File: rtl/point_encode.sv
// Compresses an extended-coordinate Ed25519 point (X:Y:Z) into the 256-bit encoding {x[0], y[254:0]}.
// Z is inverted as Z^(q-2) on one MSB-first interleaved modular multiplier (256 cycles per product).
module point_encode #(
    parameter int unsigned  B = 256,
    parameter logic [B-1:0] Q = B'(256'h7fffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffed)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [B-1:0] x,
    input  logic [B-1:0] y,
    input  logic [B-1:0] z,
    output logic         busy,
    output logic         done,
    output logic [B-1:0] enc
);

    localparam int unsigned   AW = B + 1;
    localparam int unsigned   CW = $clog2(B);
    localparam logic [B-1:0]  E  = Q - B'(2);
    localparam logic [AW-1:0] QA = AW'(Q);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EXP  = 3'd1,
        S_MULX = 3'd2,
        S_MULY = 3'd3,
        S_PACK = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    state_t         r_state;
    state_t         w_next;

    logic [B-1:0]   r_x;
    logic [B-1:0]   r_y;
    logic [B-1:0]   r_z;
    logic [B-1:0]   r_r;
    logic           r_xa0;
    logic [B-2:0]   r_ya;
    logic [B-1:0]   r_ma;
    logic [B-1:0]   r_mb;
    logic [B-1:0]   r_acc;
    logic [CW-1:0]  r_cyc;
    logic [CW-1:0]  r_bit;
    logic           r_phase;
    logic           r_busy;
    logic           r_done;
    logic [B-1:0]   r_enc;

    logic           w_in_mul;
    logic           w_last;
    logic           w_ebit;
    logic           w_exp_step;
    logic           w_exp_done;
    logic           w_accept;
    logic           w_load;
    logic           w_pack;
    logic           w_fin;
    logic [B-1:0]   w_opb;
    logic [AW-1:0]  w_dbl;
    logic [AW-1:0]  w_dbl_r;
    logic [AW-1:0]  w_sum;
    logic [B-1:0]   w_prod;

    // Product boundaries and exponent scan position
    assign w_in_mul   = (r_state == S_EXP) || (r_state == S_MULX) || (r_state == S_MULY);
    assign w_last     = w_in_mul && (r_cyc == CW'(B - 1));
    assign w_ebit     = E[r_bit];
    // A bit is finished after its squaring when e[i]=0, or after the multiply by z when e[i]=1
    assign w_exp_step = r_phase || !w_ebit;
    assign w_exp_done = w_exp_step && (r_bit == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = S_EXP;
            S_EXP:  if (w_last && w_exp_done) w_next = S_MULX;
            S_MULX: if (w_last) w_next = S_MULY;
            S_MULY: if (w_last) w_next = S_PACK;
            S_PACK: w_next = S_FIN;
            S_FIN:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Per-state control strobes and multiplier operand select
    always_comb begin
        w_accept = 1'b0;
        w_load   = 1'b0;
        w_pack   = 1'b0;
        w_fin    = 1'b0;
        w_opb    = r_r;
        case (r_state)
            S_IDLE: w_accept = start;
            S_EXP: begin
                w_load = (r_cyc == '0);
                w_opb  = r_phase ? r_z : r_r;
            end
            S_MULX: begin
                w_load = (r_cyc == '0);
                w_opb  = r_x;
            end
            S_MULY: begin
                w_load = (r_cyc == '0);
                w_opb  = r_y;
            end
            S_PACK: w_pack = 1'b1;
            S_FIN:  w_fin  = 1'b1;
            default: ;
        endcase
    end

    // One interleaved iteration: double, reduce, conditionally add a, reduce
    always_comb begin
        w_dbl   = {r_acc, 1'b0};
        w_dbl_r = (w_dbl >= QA) ? (w_dbl - QA) : w_dbl;
        w_sum   = w_dbl_r + (r_mb[B-2] ? AW'(r_ma) : '0);
        w_prod  = B'((w_sum >= QA) ? (w_sum - QA) : w_sum);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_r     <= '0;
            r_xa0   <= 1'b0;
            r_ya    <= '0;
            r_ma    <= '0;
            r_mb    <= '0;
            r_acc   <= '0;
            r_cyc   <= '0;
            r_bit   <= '0;
            r_phase <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_enc   <= '0;
        end else begin
            // Exponent bit 254 is 1, so the accumulator starts at z
            if (w_accept) begin
                r_x     <= x;
                r_y     <= y;
                r_z     <= z;
                r_r     <= z;
                r_bit   <= CW'(B - 3);
                r_phase <= 1'b0;
                r_cyc   <= '0;
                r_busy  <= 1'b1;
                r_done  <= 1'b0;
            end

            if (w_in_mul) begin
                r_cyc <= r_cyc + CW'(1);
            end

            if (w_load) begin
                r_acc <= '0;
                r_ma  <= r_r;
                r_mb  <= w_opb;
            end else if (w_in_mul) begin
                r_acc <= w_prod;
                r_mb  <= r_mb << 1;
            end

            if (w_last) begin
                case (r_state)
                    S_EXP: begin
                        r_r <= w_prod;
                        if (w_exp_step) begin
                            r_phase <= 1'b0;
                            if (r_bit != '0) begin
                                r_bit <= r_bit - CW'(1);
                            end
                        end else begin
                            r_phase <= 1'b1;
                        end
                    end
                    S_MULX:  r_xa0 <= w_prod[0];
                    S_MULY:  r_ya  <= w_prod[B-2:0];
                    default: ;
                endcase
            end

            if (w_pack) begin
                r_enc <= {r_xa0, r_ya};
            end

            if (w_fin) begin
                r_done <= 1'b1;
                r_busy <= 1'b0;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign enc  = r_enc;

endmodule

// File: tb/tb_point_encode.sv
// Scoreboard bench for point_encode: the driver queues expected encodings at each accepted start,
// the monitor pops and checks enc, latency and busy whenever done rises.
module tb_point_encode;

    localparam int unsigned B   = 256;
    localparam logic [255:0] Q  = 256'h7fffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffed;
    localparam int unsigned LAT = 130050;
    localparam logic [255:0] BX = 256'h216936d3cd6e53fec0a4e231fdd6dc5c692cc7609525a7b2c9562d608f25d51a;
    localparam logic [255:0] BY = 256'h6666666666666666666666666666666666666666666666666666666666666658;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [255:0] x;
    logic [255:0] y;
    logic [255:0] z;
    logic         busy;
    logic         done;
    logic [255:0] enc;

    int           tests = 0;
    int           fails = 0;
    int unsigned  cyc = 0;
    int           busy_gap = 0;
    logic         prev_done = 1'b0;
    logic [255:0] exp_q[$];
    int unsigned  acc_q[$];

    point_encode #(.B(B), .Q(Q)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x),
        .y     (y),
        .z     (z),
        .busy  (busy),
        .done  (done),
        .enc   (enc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference field arithmetic with plain wide integers
    function automatic logic [255:0] mulmod(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] p;
        p = 512'(a) * 512'(b);
        return 256'(p % 512'(Q));
    endfunction

    function automatic logic [255:0] model(input logic [255:0] xv, input logic [255:0] yv,
                                           input logic [255:0] zv);
        logic [255:0] e;
        logic [255:0] zi;
        logic [255:0] xa;
        logic [255:0] ya;
        e  = Q - 256'd2;
        zi = 256'd1;
        for (int i = 255; i >= 0; i--) begin
            zi = mulmod(zi, zi);
            if (e[i]) zi = mulmod(zi, zv);
        end
        xa = mulmod(xv, zi);
        ya = mulmod(yv, zi);
        return {xa[0], ya[254:0]};
    endfunction

    function automatic logic [255:0] rnd_fe();
        logic [255:0] v;
        v = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
        return v % Q;
    endfunction

    // Monitor: check every rising done against the oldest queued expectation
    always @(negedge clk) begin
        logic [255:0] e;
        int unsigned  a;
        if (done && !prev_done) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: enc %h with nothing outstanding", enc);
            end else begin
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                chk("enc", enc, e);
                chk("latency", 256'(cyc - a), 256'(LAT));
                chk("busy_gaps", 256'(busy_gap), 256'd0);
                chk("busy_at_done", 256'(busy), 256'd0);
                busy_gap = 0;
            end
        end else if (!done && exp_q.size() > 0 && cyc >= acc_q[0] && !busy) begin
            busy_gap++;
        end
        prev_done = done;
    end

    task automatic finish_tb();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    // Called at a negedge; start is accepted on the following posedge
    task automatic issue(input logic [255:0] xv, input logic [255:0] yv, input logic [255:0] zv,
                         input logic [255:0] ev);
        x     = xv;
        y     = yv;
        z     = zv;
        start = 1'b1;
        exp_q.push_back(ev);
        acc_q.push_back(cyc + 1);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < LAT + 100) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: done still %b after %0d cycles", done, n);
            finish_tb();
        end
    endtask

    initial begin
        logic [255:0] e_a;
        logic [255:0] xr;
        logic [255:0] yr;
        logic [255:0] zr;
        e_a   = {1'b1, 255'd5};
        rst   = 1'b1;
        start = 1'b0;
        x     = '0;
        y     = '0;
        z     = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 256'(busy), 256'd0);
        chk("reset_done", 256'(done), 256'd0);
        chk("reset_enc", enc, 256'd0);
        rst = 1'b0;
        @(negedge clk);

        // 3/5/1 with a stray start mid-operation that must be ignored
        issue(256'd3, 256'd5, 256'd1, e_a);
        repeat (1000) @(negedge clk);
        x     = 256'd4;
        y     = 256'd6;
        z     = 256'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);
        chk("done_held", 256'(done), 256'd1);
        chk("enc_held", enc, e_a);

        // Abort with an asynchronous reset part-way through
        issue(256'd7, 256'd9, 256'd1, 256'd0);
        repeat (4998) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 256'(busy), 256'd0);
        chk("abort_done", 256'(done), 256'd0);
        chk("abort_enc", enc, 256'd0);
        exp_q.delete();
        acc_q.delete();
        busy_gap = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue(256'd3, 256'd5, 256'd1, e_a);
        wait_done();
        // Remaining operations are issued back-to-back on the first done cycle
        issue(256'd4, 256'd6, 256'd2, 256'd3);
        wait_done();
        issue(256'd1, 256'd2, Q - 256'd1, Q - 256'd2);
        wait_done();
        issue(BX, BY, 256'd1, BY);
        wait_done();
        issue(256'd7, 256'd9, 256'd0, 256'd0);
        wait_done();
        xr = rnd_fe();
        yr = rnd_fe();
        zr = rnd_fe();
        if (zr == '0) zr = 256'd1;
        issue(xr, yr, zr, model(xr, yr, zr));
        wait_done();

        repeat (2) @(negedge clk);
        chk("queue_drained", 256'(exp_q.size()), 256'd0);
        finish_tb();
    end

endmodule

// File: doc/point_encode.md
# point_encode

Converts an extended-coordinate Ed25519 point (X:Y:Z), as produced by `point_add`, into the standard 256-bit compressed encoding. It computes x = X/Z and y = Y/Z mod q, then packs y[254:0] with the sign bit x[0] in bit 255. The inversion uses a Fermat exponentiation, Z^(q-2), on one internal bit-serial modular multiplier. The block sits at the output end of the point-arithmetic datapath, feeding signature and public-key serialisation.

## Interface
Parameters:
- `B`, default 256: coordinate and encoding width.
- `Q`, default 2^255-19: field prime. Synthesis supports only the default.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request. Sampled only in IDLE.
- `x`, `y`, `z` in B each: projective coordinates. The T coordinate is not needed.
- `busy` out 1: high from the cycle after start is accepted until `done` rises.
- `done` out 1: level. High from completion until the next accepted `start` or reset.
- `enc` out B: compressed point. Valid while `done` is high.

## Operation
- Input contract:
  - x, y and z must each be < q; otherwise `enc` is unspecified.
  - z = 0 is legal. Z^(q-2) = 0, so the block produces enc = 0.
- FSM states: IDLE, EXP, MULX, MULY, PACK, FIN.
- IDLE:
  - If start=1, latch x, y, z and set r = z, which accounts for exponent bit 254 being 1.
  - Clear `done`, go to EXP with bit index i = 253.
- EXP scans exponent e = q-2 = 2^255-21 from bit 253 down to bit 0:
  - r = r·r mod q.
  - If e[i]=1, then r = r·z mod q.
  - Bits 2 and 4 are 0; all other bits of 253..0 are 1.
  - Total 254 squarings and 252 multiplies.
- MULX: xa = X·r mod q.
- MULY: ya = Y·r mod q.
- PACK: enc = {xa[0], ya[254:0]}.
- FIN: assert `done`, deassert `busy`, return to IDLE. `enc` and `done` hold.
- Multiplier: MSB-first interleaved, 1 load cycle plus 255 iteration cycles = 256 cycles per product. Each iteration:
  - acc = 2·acc; subtract q if acc ≥ q.
  - If b[j], then acc = acc + a; subtract q if the result ≥ q.
  - acc needs 257 bits internally. The result is always < q.
- `start` while busy is ignored and the latched operands are unchanged.
- Reset at any time forces IDLE, busy=0, done=0, enc=0. It aborts any operation in progress with no partial result.

## Timing
- Reset values: busy=0, done=0, enc=0. All internal registers are also cleared.
- Accept: on the edge where the FSM is in IDLE and start=1. busy=1 from the next cycle.
- Fixed latency:
  - Multiplies: 508 × 256 = 130048 cycles.
  - Plus 1 PACK cycle and 1 FIN cycle.
  - `done` rises exactly 130050 edges after the accept edge. `enc` is valid on the same edge.
- Back-to-back: start may be asserted in the same cycle `done` first reads high. It is accepted on the next edge, which clears `done`.
- Latency does not depend on the data, including z = 0.

## Test plan
- X=3, Y=5, Z=1: enc = 2^255+5 at exactly 130050 cycles. Check busy high throughout and done held afterwards.
- X=4, Y=6, Z=2: x=2, y=3, so enc = 3.
- X=1, Y=2, Z=q-1: x=q-1 (even), y=q-2, so enc = q-2.
- Ed25519 base point in affine form (Z=1, X=Bx, Y=By=4/5): enc = 0x6666…6658, with sign bit 0.
- start pulsed again mid-operation with different inputs: ignored. The first result is unchanged and done appears at the original cycle.
- rst asserted at cycle 5000 of an operation: outputs are 0 immediately (asynchronously). A new start with X=3, Y=5, Z=1 then gives enc = 2^255+5 after 130050 cycles.
- X=7, Y=9, Z=0: enc = 0.
